// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves RV32I-style conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) over an
// XLEN-wide datapath. The unit computes the branch target and the next PC, and
// flags a misprediction against the front-end prediction. It is a two-stage
// valid/ready pipeline:
//   S1 : operand register (funct3, A, B, pc, imm, pred_taken)
//   S2 : result register  (compare flags, taken, mispredict, illegal, next_pc)
// Accept-to-result latency is 2 cycles. Throughput is one request per cycle
// while out_ready is held high.
//
// Optional feature: define BR_PERF_CNT_EN to build saturating performance
// counters on branch_cnt / mispred_cnt. Without the macro, both ports are tied
// to 0.
//
// Parameters
//   XLEN   : operand / PC / immediate width (16..64)
//   PC_INC : fall-through PC increment
//   CNT_W  : performance counter width
//
// Ports
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : request handshake (in_ready is 0 in reset and flush)
//   funct3, A, B, pc,
//   imm, pred_taken     : request payload
//   flush               : kill every in-flight request at the next edge
//   out_valid/out_ready : result handshake
//   BrEq, BrLT          : A == B, A < B (signed/unsigned per funct3[1])
//   taken, mispredict   : branch outcome and (taken != pred_taken)
//   illegal             : funct3 is 010 or 011
//   next_pc             : taken ? pc + imm : pc + PC_INC (mod 2^XLEN)
//   branch_cnt          : legal results delivered (BR_PERF_CNT_EN)
//   mispred_cnt         : mispredicted legal results delivered (BR_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  A,
  input  logic [XLEN-1:0]  B,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             BrEq,
  output logic             BrLT,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic [XLEN-1:0]  next_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [XLEN-1:0] PcIncrement = XLEN'(PC_INC);

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic readyEn;   // keeps in_ready low until the first edge after reset
  logic s1Valid;
  logic s2Valid;
  logic adv2;      // S2 may take new data this cycle
  logic accept;    // request enters S1
  logic s1Adv;     // S1 contents move into S2

  assign adv2     = !s2Valid || out_ready;
  assign in_ready = readyEn && !flush && (adv2 || !s1Valid);
  assign accept   = in_valid && in_ready;
  assign s1Adv    = s1Valid && adv2 && !flush;

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyEn <= 1'b0;
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (flush) begin
        // Flush wins over both capture and stall.
        s1Valid <= 1'b0;
        s2Valid <= 1'b0;
      end else begin
        if (adv2) begin
          s2Valid <= s1Valid;
        end
        if (accept) begin
          s1Valid <= 1'b1;
        end else if (s1Adv) begin
          s1Valid <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1 operand register
  // ---------------------------------------------------------------------------
  logic [2:0]      s1Funct3;
  logic [XLEN-1:0] s1A;
  logic [XLEN-1:0] s1B;
  logic [XLEN-1:0] s1Pc;
  logic [XLEN-1:0] s1Imm;
  logic            s1PredTaken;

  // NOTE: pure payload registers carry no reset; s1Valid qualifies them, so
  // their power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1Funct3    <= funct3;
      s1A         <= A;
      s1B         <= B;
      s1Pc        <= pc;
      s1Imm       <= imm;
      s1PredTaken <= pred_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Resolution logic between S1 and S2
  // ---------------------------------------------------------------------------
  logic            rEq;
  logic            rLt;
  logic            rTaken;
  logic            rIllegal;
  logic            rMispredict;
  logic [XLEN-1:0] rTarget;
  logic [XLEN-1:0] rFallThrough;
  logic [XLEN-1:0] rNextPc;

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a variable unassigned and no latch is inferred.
    rTaken   = 1'b0;
    rIllegal = 1'b0;
    rEq      = (s1A == s1B);
    // funct3[1] selects the unsigned flavour (BLTU/BGEU).
    rLt      = s1Funct3[1] ? (s1A < s1B) : ($signed(s1A) < $signed(s1B));
    case (s1Funct3)
      3'b000:  rTaken = rEq;
      3'b001:  rTaken = !rEq;
      3'b100:  rTaken = rLt;
      3'b101:  rTaken = !rLt;
      3'b110:  rTaken = rLt;
      3'b111:  rTaken = !rLt;
      default: rIllegal = 1'b1;   // 010 / 011 are not branches
    endcase
    // An illegal branch is never taken, so mispredict reduces to pred_taken.
    rMispredict  = (rTaken != s1PredTaken);
    rTarget      = s1Pc + s1Imm;          // wraps modulo 2^XLEN
    rFallThrough = s1Pc + PcIncrement;    // wraps modulo 2^XLEN
    rNextPc      = rTaken ? rTarget : rFallThrough;
  end

  // ---------------------------------------------------------------------------
  // S2 result register. These drive the outputs directly, so they are reset
  // (outputs read 0 in reset) and load only when S1 advances, which keeps the
  // data stable under backpressure and while out_valid is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BrEq       <= 1'b0;
      BrLT       <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
      next_pc    <= '0;
    end else if (s1Adv) begin
      BrEq       <= rEq;
      BrLT       <= rLt;
      taken      <= rTaken;
      mispredict <= rMispredict;
      illegal    <= rIllegal;
      next_pc    <= rNextPc;
    end
  end

  assign out_valid = s2Valid;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef BR_PERF_CNT_EN
  logic             outFire;
  logic [CNT_W-1:0] branchCnt;
  logic [CNT_W-1:0] mispredCnt;

  assign outFire = s2Valid && out_ready;

  // Counters track delivered results only; flush does not touch them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else if (outFire && !illegal) begin
      if (branchCnt != '1) begin
        branchCnt <= branchCnt + CNT_W'(1);
      end
      if (mispredict && (mispredCnt != '1)) begin
        mispredCnt <= mispredCnt + CNT_W'(1);
      end
    end
  end

  assign branch_cnt  = branchCnt;
  assign mispred_cnt = mispredCnt;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit. A transaction-level reference
// model keeps a queue of expected results with their age in cycles. A result
// becomes visible two edges after it is accepted, and the queue is emptied on
// flush or reset. Directed steps cover the listed scenarios, followed by a
// randomized phase. Counter expectations follow BR_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  A;
  logic [XLEN-1:0]  B;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             BrEq;
  logic             BrLT;
  logic             taken;
  logic             mispredict;
  logic             illegal;
  logic [XLEN-1:0]  next_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN  (XLEN),
    .PC_INC(4),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .A          (A),
    .B          (B),
    .pc         (pc),
    .imm        (imm),
    .pred_taken (pred_taken),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .BrEq       (BrEq),
    .BrLT       (BrLT),
    .taken      (taken),
    .mispredict (mispredict),
    .illegal    (illegal),
    .next_pc    (next_pc),
    .branch_cnt (branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic            eq;
    logic            lt;
    logic            tk;
    logic            mp;
    logic            il;
    logic [XLEN-1:0] npc;
    int              age;
  } res_t;

  res_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   expBr   = 0;
  int   expMp   = 0;
  localparam int CntMax = (1 << CNT_W) - 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural branch rules.
  function automatic res_t model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] p,
                                 input logic [XLEN-1:0] im, input logic pt);
    res_t   r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint modulus = longint'(1) << XLEN;
    r.eq  = (ua == ub);
    r.lt  = f[1] ? (ua < ub) : (sa < sb);
    r.il  = (f == 3'd2) || (f == 3'd3);
    case (f)
      3'd0: r.tk = r.eq;
      3'd1: r.tk = !r.eq;
      3'd4, 3'd6: r.tk = r.lt;
      3'd5, 3'd7: r.tk = !r.lt;
      default: r.tk = 1'b0;
    endcase
    r.mp  = (r.tk != pt);
    r.npc = XLEN'(r.tk ? (ua + longint'(im)) % modulus : (ua + 4) % modulus);
    r.npc = XLEN'(r.tk ? (longint'(p) + longint'(im)) % modulus
                       : (longint'(p) + 4) % modulus);
    r.age = 0;
    return r;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] p, input logic [XLEN-1:0] im, input logic pt);
    in_valid = 1'b1; funct3 = f; A = a; B = b; pc = p; imm = im; pred_taken = pt;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock cycle: check against the model at the negedge, update the model
  // for the coming edge, then return at posedge+1 ready for new stimulus.
  task automatic tick();
    res_t h;
    logic hasOut;
    logic expReady;
    @(negedge clk);
    expReady = !flush && ((q.size() < 2) || out_ready);
    hasOut   = (q.size() > 0) && (q[0].age >= 2);
    check("in_ready", in_ready, expReady);
    check("out_valid", out_valid, hasOut);
`ifdef BR_PERF_CNT_EN
    check("branch_cnt", branch_cnt, expBr);
    check("mispred_cnt", mispred_cnt, expMp);
`else
    check("branch_cnt_tied", branch_cnt, 0);
    check("mispred_cnt_tied", mispred_cnt, 0);
`endif
    if (hasOut) begin
      check("BrEq", BrEq, q[0].eq);
      check("BrLT", BrLT, q[0].lt);
      check("taken", taken, q[0].tk);
      check("mispredict", mispredict, q[0].mp);
      check("illegal", illegal, q[0].il);
      check("next_pc", next_pc, q[0].npc);
      if (out_ready) begin
        h = q.pop_front();
        if (!h.il) begin
          if (expBr < CntMax) expBr++;
          if (h.mp && (expMp < CntMax)) expMp++;
        end
      end
    end
    if (flush) q.delete();
    else if (in_valid && expReady) q.push_back(model(funct3, A, B, pc, imm, pred_taken));
    foreach (q[i]) q[i].age++;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_BrEq", BrEq, 0);
    check("rst_BrLT", BrLT, 0);
    check("rst_taken", taken, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_illegal", illegal, 0);
    check("rst_next_pc", next_pc, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    q.delete(); expBr = 0; expMp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct3 = '0; A = '0; B = '0; pc = '0; imm = '0; pred_taken = 1'b0;
    doReset();

    // Signed compare: BLT -5000 < -5001 is false.
    drive(3'b100, 32'hFFFF_EC78, 32'hFFFF_EC77, 32'h0000_0200, 32'h0000_0040, 1'b1);
    tick(); idle(); tick();
    check("blt_valid", out_valid, 1);
    check("blt_BrLT", BrLT, 0);
    check("blt_taken", taken, 0);
    check("blt_mispredict", mispredict, 1);
    check("blt_next_pc", next_pc, 32'h0000_0204);
    tick();

    // Unsigned compare: BLTU then BGEU back to back.
    drive(3'b110, 32'd100, 32'd5000, 32'h0000_0100, 32'h0000_0020, 1'b0);
    tick();
    drive(3'b111, 32'hFFFF_FB2E, 32'hFFFF_FB2E, 32'h0000_0300, 32'h0000_0008, 1'b1);
    tick(); idle();
    check("bltu_taken", taken, 1);
    check("bltu_next_pc", next_pc, 32'h0000_0120);
    tick();
    check("bgeu_BrEq", BrEq, 1);
    check("bgeu_taken", taken, 1);
    check("bgeu_next_pc", next_pc, 32'h0000_0308);
    tick();

    // Streaming: four back-to-back requests give four consecutive results.
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(7)), $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(1)));
      tick();
      if (i >= 1) check("stream_valid", out_valid, 1);
    end
    idle(); tick();
    check("stream_last_valid", out_valid, 1);
    tick();
    check("stream_drained", out_valid, 0);

    // Backpressure: fill S1 and S2, hold out_ready low for 3 cycles.
    drive(3'b000, 32'd9, 32'd9, 32'h0000_1000, 32'h0000_0010, 1'b0);
    tick();
    drive(3'b001, 32'd1, 32'd2, 32'h0000_2000, 32'h0000_0020, 1'b1);
    tick();
    out_ready = 1'b0;
    drive(3'b101, 32'd3, 32'd4, 32'h0000_3000, 32'h0000_0030, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready_low", in_ready, 0);
      tick();
      check("bp_hold_next_pc", next_pc, 32'h0000_1010);
    end
    out_ready = 1'b1;
    tick(); idle();
    for (int c = 0; c < 3; c++) tick();
    check("bp_drained", out_valid, 0);

    // Flush with both stages full and a new request offered.
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 32'h0000_4000, 32'h0000_0004, 1'b1);
    tick();
    drive(3'b100, 32'd1, 32'd2, 32'h0000_5000, 32'h0000_0008, 1'b1);
    tick();
    drive(3'b110, 32'd5, 32'd6, 32'h0000_6000, 32'h0000_000C, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; idle();
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    // Next request completes normally: BEQ with PC wrap.
    drive(3'b000, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1);
    tick(); idle(); tick();
    check("wrap_valid", out_valid, 1);
    check("wrap_taken", taken, 1);
    check("wrap_next_pc", next_pc, 32'h0000_0010);
    tick();

    // Illegal funct3.
    drive(3'b010, 32'd1, 32'd1, 32'h0000_7000, 32'h0000_0040, 1'b1);
    tick(); idle(); tick();
    check("illegal_flag", illegal, 1);
    check("illegal_taken", taken, 0);
    check("illegal_mispredict", mispredict, 1);
    tick();

    // Reset pulsed mid-stream.
    drive(3'b000, 32'd2, 32'd2, 32'h0000_8000, 32'h0000_0010, 1'b0);
    tick(); tick();
    doReset();

    // Counters: 5 legal branches, 2 of them mispredicted.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(3'b000, 32'd4, 32'd4, 32'h0000_9000, 32'h0000_0010, 1'b1);
      else       drive(3'b001, 32'd4, 32'd4, 32'h0000_9000, 32'h0000_0010, 1'b1);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
`ifdef BR_PERF_CNT_EN
    check("cnt_branch_5", branch_cnt, 5);
    check("cnt_mispred_2", mispred_cnt, 2);
`else
    check("cnt_branch_off", branch_cnt, 0);
    check("cnt_mispred_off", mispred_cnt, 0);
`endif

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      logic [XLEN-1:0] ra;
      logic [XLEN-1:0] rb;
      ra = $urandom;
      rb = ($urandom_range(3) == 0) ? ra : (($urandom_range(1) == 1) ? ra + XLEN'($urandom_range(2)) : $urandom);
      if ($urandom_range(3) != 0) drive(3'($urandom_range(7)), ra, rb, $urandom, $urandom, 1'($urandom_range(1)));
      else idle();
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(31) == 0);
      tick();
    end
    idle(); flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("final_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised, pipelined successor to the combinational branch comparator in the RV32I core. It resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) over an XLEN-wide datapath, computes the branch target and next PC, and flags mispredictions against a front-end prediction. It has a two-stage valid/ready pipeline between the execute and PC-select logic, with flush support and optional performance counters.

Parameters:
XLEN, 32, operand, PC and immediate width in bits (legal values: 16 to 64).
PC_INC, 4, fall-through PC increment.
CNT_W, 32, width of the optional performance counters.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  request valid.
in_ready  output  1  unit accepts the request this cycle.
funct3  input  3  branch type (RISC-V encoding).
A  input  XLEN  rs1 operand.
B  input  XLEN  rs2 operand.
pc  input  XLEN  branch instruction PC.
imm  input  XLEN  sign-extended B-type immediate.
pred_taken  input  1  front-end prediction.
flush  input  1  kill all in-flight requests.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
BrEq  output  1  A == B.
BrLT  output  1  A < B, signed or unsigned per funct3.
taken  output  1  branch resolved as taken.
mispredict  output  1  taken != pred_taken.
illegal  output  1  funct3 is 010 or 011.
next_pc  output  XLEN  taken ? target : pc + PC_INC.
branch_cnt  output  CNT_W  resolved-branch count (optional feature).
mispred_cnt  output  CNT_W  misprediction count (optional feature).

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0. All outputs are 0, including in_ready. in_ready rises on the first clk edge after rst deasserts. Asserting rst mid-operation discards all in-flight work immediately.
- S1 (operand register): captures funct3/A/B/pc/imm/pred_taken when in_valid && in_ready.
- S2 (result register): captures the comparison, target and flags computed from S1 when S1 advances.
- Handshake and stalls:
  - adv2 = !s2_valid || out_ready.
  - in_ready = adv2 || !s1_valid.
  - Holding: S2 holds while out_valid && !out_ready. S1 holds when S2 is blocked. No bubble is inserted when both stages stream.
- Latency and throughput: 2 cycles from accept to out_valid. Throughput is 1 request per cycle with out_ready held high.
- Compare:
  - BrEq = (A == B).
  - funct3[1]=0: BrLT is the signed compare.
  - funct3[1]=1: BrLT is the unsigned compare.
- Taken, by funct3:
  - 000 BEQ: eq.
  - 001 BNE: !eq.
  - 100 BLT: lt.
  - 101 BGE: !lt.
  - 110 BLTU: ltu.
  - 111 BGEU: !ltu.
  - 010/011: taken=0, illegal=1, mispredict=pred_taken.
- Arithmetic: target = pc + imm, and pc + PC_INC, both modulo 2^XLEN (wrap, no overflow flag).
- Flush:
  - Clears s1_valid and s2_valid at the next edge. in_ready is forced to 0 during a flush cycle, so a same-cycle in_valid is dropped.
  - Flush has priority over stall and capture. Data registers need not clear.
- Output stability: outputs stay stable while out_valid && !out_ready. With out_valid=0, data outputs hold their last values.

Optional Feature:
Macro BR_PERF_CNT_EN.
- Defined: branch_cnt increments on each out_valid && out_ready handshake with illegal=0. mispred_cnt increments on the same handshake when mispredict=1. Both saturate at all-ones, reset to 0 on rst, and are not affected by flush.
- Undefined: both ports remain in the interface, tied to 0, and no counter logic is synthesised.

Test Plan:
- Signed compare: BLT, A=-5000, B=-5001, pred_taken=1 -> 2 cycles later BrLT=0, taken=0, mispredict=1, next_pc=pc+4.
- Unsigned compare: BLTU, A=100, B=5000, pc=0x100, imm=0x20 -> taken=1, next_pc=0x120. Then BGEU, A=-1234, B=-1234 -> BrEq=1, taken=1.
- Streaming and backpressure: 4 back-to-back requests with out_ready=1 -> 4 results on consecutive cycles. Drop out_ready for 3 cycles mid-stream -> outputs held, in_ready=0 once S1 and S2 are full, no loss or duplication.
- Flush: flush asserted with S1 and S2 full and in_valid=1 -> out_valid=0 next cycle, the new request dropped, the next request completes normally.
- Wrap and illegal: pc=0xFFFFFFF0, imm=0x20, BEQ with equal operands -> next_pc=0x10. funct3=010, pred_taken=1 -> illegal=1, taken=0, mispredict=1.
- Reset and counters: rst pulsed mid-stream -> all outputs 0 immediately. With BR_PERF_CNT_EN, 5 branches with 2 mispredicts -> branch_cnt=5, mispred_cnt=2. With CNT_W=2, 4 mispredicts -> mispred_cnt saturates at 3.
